// File: rtl/button_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// button_debouncer_pkg
//   Shared definitions for the push-button debouncer:
//     - state_t      : FSM state encodings (also exposed on the debug port)
//     - defaults     : qualification time for a 50 MHz clock and 10 ms window
//     - helpers      : released pad level for a given polarity, and the
//                      debounced level implied by an FSM state
// -----------------------------------------------------------------------------
package button_debouncer_pkg;

    // Encodings are visible on the debug port, so they are fixed explicitly.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,   // released and stable
        PRESS_WAIT   = 2'b01,   // press seen, qualifying
        PRESSED      = 2'b10,   // pressed and stable
        RELEASE_WAIT = 2'b11    // release seen, qualifying
    } state_t;

    localparam int DEFAULT_CLK_HZ        = 50_000_000;
    localparam int DEFAULT_DEBOUNCE_MS   = 10;
    localparam int DEFAULT_STABLE_CYCLES = (DEFAULT_CLK_HZ / 1000) * DEFAULT_DEBOUNCE_MS;
    localparam int DEFAULT_CNT_W         = 20;

    // Pad value while the button is not pressed.
    function automatic logic released_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

    // The debounced output reads "pressed" from the moment a press is
    // accepted until a release is accepted, i.e. in PRESSED and in
    // RELEASE_WAIT (a release still being qualified keeps the level high).
    function automatic logic level_of(input state_t s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage : button_debouncer_pkg

// File: rtl/button_debouncer_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for a single asynchronous input. Both flops load
//   RESET_VAL under reset so that the synchronized value leaving reset is a
//   known, harmless level chosen by the instantiating block.
//
// Ports
//   clk    in  1  destination clock, rising edge
//   reset  in  1  asynchronous, active-low reset
//   d      in  1  asynchronous input
//   q      out 1  synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // First stage may go metastable; it feeds nothing but the second stage.
    logic sync1;

    // NOTE: state is updated with non-blocking assignments so that every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the two stages into one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= RESET_VAL;
            q     <= RESET_VAL;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule : sync_2ff

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Turns one raw, bouncing, asynchronous push-button pad into a clean,
//   synchronous "pressed" level for the downstream level-to-pulse stage.
//
//   Path: pad -> 2-flop synchronizer -> polarity normalisation -> 4-state
//   counter-qualified FSM -> registered level.
//
//   A change of the pad has to be seen on STABLE_CYCLES consecutive qualify
//   edges before it is accepted; any opposite sample while qualifying aborts
//   the attempt and returns to the previous stable state with no credit kept.
//   With the pad held stable, level follows on rising edge STABLE_CYCLES+3
//   counted from the first edge that samples the new pad value.
//
// Parameters
//   ACTIVE_LOW     1: pad reads 0 when pressed; 0: pad reads 1 when pressed
//   STABLE_CYCLES  qualification length in clk cycles, >= 1
//   CNT_W          counter width, STABLE_CYCLES <= 2**CNT_W
//
// Ports
//   clk     in  1  system clock, rising edge
//   reset   in  1  asynchronous, active-low reset
//   button  in  1  raw pad input, asynchronous to clk, may bounce
//   level   out 1  debounced pressed level, registered, 1 = pressed
//   state   out 2  current FSM state (debug / observation)
// -----------------------------------------------------------------------------
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic       level,
    output logic [1:0] state
);

    // Synchronizer flops come out of reset at the released pad value, so
    // releasing reset never looks like a press edge to the FSM.
    localparam logic RELEASED_PAD = released_level(ACTIVE_LOW);

    // Terminal count: the qualify edge that sees cnt at this value is the
    // STABLE_CYCLES-th one and performs the transition.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic button_sync;
    logic pressed_s;

    sync_2ff #(
        .RESET_VAL (RELEASED_PAD)
    ) u_sync_button (
        .clk   (clk),
        .reset (reset),
        .d     (button),
        .q     (button_sync)
    );

    // From here on 1 always means "pressed", whatever the board polarity.
    assign pressed_s = ACTIVE_LOW ? ~button_sync : button_sync;

    // -------------------------------------------------------------------------
    // FSM, qualify counter and level register
    // -------------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_d;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a
    // latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!pressed_s) begin
                    // Bounce: drop the attempt entirely.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end

            RELEASE_WAIT: begin
                if (pressed_s) begin
                    // Bounce on release: the press is still the stable state.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Level is computed from the next state so the registered output
        // changes on the very edge that enters PRESSED or IDLE.
        level_d = level_of(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
        end
    end

    assign state = state_q;

endmodule : button_debouncer

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//   Three debouncer instances share clk and reset:
//     sel 0: ACTIVE_LOW=1, STABLE_CYCLES=4, CNT_W=3  (main instance)
//     sel 1: ACTIVE_LOW=0, STABLE_CYCLES=4, CNT_W=3  (active-high pad)
//     sel 2: ACTIVE_LOW=1, STABLE_CYCLES=1, CNT_W=1  (shortest qualification)
//   Expected {level, state} values are queued as each edge's stimulus is
//   driven and are popped and compared once the DUT has updated (#1 after
//   the rising edge). Inputs change only at that same point, well away from
//   the next active edge.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button_al;
    logic       button_ah;
    logic       button_s1;
    logic       level_al;
    logic       level_ah;
    logic       level_s1;
    logic [1:0] state_al;
    logic [1:0] state_ah;
    logic [1:0] state_s1;

    always #5 clk = ~clk;

    button_debouncer #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(4), .CNT_W(3)) dut_al (
        .clk    (clk),
        .reset  (reset),
        .button (button_al),
        .level  (level_al),
        .state  (state_al)
    );

    button_debouncer #(.ACTIVE_LOW(1'b0), .STABLE_CYCLES(4), .CNT_W(3)) dut_ah (
        .clk    (clk),
        .reset  (reset),
        .button (button_ah),
        .level  (level_ah),
        .state  (state_ah)
    );

    button_debouncer #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(1), .CNT_W(1)) dut_s1 (
        .clk    (clk),
        .reset  (reset),
        .button (button_s1),
        .level  (level_s1),
        .state  (state_s1)
    );

    // Scoreboard entry: which instance, what edge, expected {level, state}.
    typedef struct {
        string      name;
        int         sel;
        int         edge_no;
        logic [2:0] exp_val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // {level, state} of the selected instance.
    function automatic logic [2:0] obs(input int sel);
        case (sel)
            0:       return {level_al, state_al};
            1:       return {level_ah, state_ah};
            default: return {level_s1, state_s1};
        endcase
    endfunction

    // Expected {level, state} on edge e after the pad changes and then holds,
    // starting from the opposite stable state: 2 sync edges, 1 entry edge,
    // `stable` qualify edges.
    function automatic logic [2:0] prof(input int e, input bit rising, input int stable);
        if (rising) begin
            if (e <= 2)          return 3'b0_00;
            if (e <= 2 + stable) return 3'b0_01;
            return 3'b1_10;
        end
        if (e <= 2)          return 3'b1_10;
        if (e <= 2 + stable) return 3'b1_11;
        return 3'b0_00;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        exp_t       x;
        logic [2:0] got;
        button_al = 1'b0;   // pressed (active low) throughout reset
        button_ah = 1'b0;   // released
        button_s1 = 1'b1;   // released
        #1 reset = 1'b0;
        tick();
        tick();
        for (int s = 0; s < 3; s++) begin
            sb_q.push_back('{name:"reset_state", sel:s, edge_no:0, exp_val:3'b0_00});
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s sel %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.sel, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
        reset = 1'b1;
        // Press held through reset must be qualified from scratch.
        for (int e = 1; e <= 8; e++) begin
            sb_q.push_back('{name:"press_after_reset", sel:0, edge_no:e, exp_val:prof(e, 1'b1, 4)});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Press held 20 cycles in total (8 already done by test_reset), then release.
    task automatic test_hold_release();
        exp_t       x;
        logic [2:0] got;
        for (int e = 9; e <= 20; e++) begin
            sb_q.push_back('{name:"hold_press", sel:0, edge_no:e, exp_val:3'b1_10});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
        button_al = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            sb_q.push_back('{name:"clean_release", sel:0, edge_no:e, exp_val:prof(e, 1'b0, 4)});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Pad low 3 cycles / high 1 cycle, five times. The FSM sees pad value k-2
    // on edge k, so it enters PRESS_WAIT on edge 3 and is knocked back to IDLE
    // every fourth edge after that, never reaching the terminal count.
    task automatic test_bounce();
        exp_t       x;
        logic [2:0] got;
        logic [2:0] want;
        for (int k = 1; k <= 24; k++) begin
            button_al = (k <= 20) ? (((k - 1) % 4) == 3) : 1'b1;
            if (k <= 2 || k > 22)       want = 3'b0_00;
            else if (((k - 3) % 4) == 3) want = 3'b0_00;
            else                         want = 3'b0_01;
            sb_q.push_back('{name:"press_bounce", sel:0, edge_no:k, exp_val:want});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // In PRESSED, pad released for 2 cycles then pressed again: the release
    // attempt is aborted and level never drops.
    task automatic test_release_bounce();
        exp_t       x;
        logic [2:0] got;
        logic [2:0] want_tbl [8];
        want_tbl = '{3'b1_10, 3'b1_10, 3'b1_11, 3'b1_11, 3'b1_10, 3'b1_10, 3'b1_10, 3'b1_10};
        button_al = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            sb_q.push_back('{name:"press_for_rb", sel:0, edge_no:e, exp_val:prof(e, 1'b1, 4)});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            button_al = (e <= 2);
            sb_q.push_back('{name:"release_bounce", sel:0, edge_no:e, exp_val:want_tbl[e-1]});
            tick();
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                         x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // Asynchronous reset mid-operation: once in PRESSED (level=1), once in
    // PRESS_WAIT with cnt=2. Each time the held press is re-qualified in full.
    task automatic test_reset_mid();
        exp_t       x;
        logic [2:0] got;
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                button_al = 1'b1;
                for (int e = 1; e <= 8; e++) begin
                    sb_q.push_back('{name:"release_before_rst", sel:0, edge_no:e, exp_val:prof(e, 1'b0, 4)});
                    tick();
                    x   = sb_q.pop_front();
                    got = obs(x.sel);
                    n_cmp++;
                    if (got !== x.exp_val) begin
                        n_err++;
                        $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                                 x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
                    end
                end
                // Edges 3,4,5 give PRESS_WAIT with cnt 0,1,2.
                button_al = 1'b0;
                for (int e = 1; e <= 5; e++) begin
                    sb_q.push_back('{name:"press_to_cnt2", sel:0, edge_no:e, exp_val:prof(e, 1'b1, 4)});
                    tick();
                    x   = sb_q.pop_front();
                    got = obs(x.sel);
                    n_cmp++;
                    if (got !== x.exp_val) begin
                        n_err++;
                        $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                                 x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
                    end
                end
            end
            // Mid-cycle, away from any clock edge.
            #2 reset = 1'b0;
            sb_q.push_back('{name:(pass == 0) ? "async_rst_pressed" : "async_rst_wait",
                             sel:0, edge_no:0, exp_val:3'b0_00});
            #1;
            x   = sb_q.pop_front();
            got = obs(x.sel);
            n_cmp++;
            if (got !== x.exp_val) begin
                n_err++;
                $display("FAIL %s: got level=%b state=%b, expected level=%b state=%b",
                         x.name, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
            end
            tick();
            reset = 1'b1;
            for (int e = 1; e <= 8; e++) begin
                sb_q.push_back('{name:"requalify", sel:0, edge_no:e, exp_val:prof(e, 1'b1, 4)});
                tick();
                x   = sb_q.pop_front();
                got = obs(x.sel);
                n_cmp++;
                if (got !== x.exp_val) begin
                    n_err++;
                    $display("FAIL %s pass %0d edge %0d: got level=%b state=%b, expected level=%b state=%b",
                             x.name, pass, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_active_high();
        exp_t       x;
        logic [2:0] got;
        for (int dir = 0; dir < 2; dir++) begin
            button_ah = (dir == 0);
            for (int e = 1; e <= 8; e++) begin
                sb_q.push_back('{name:(dir == 0) ? "ah_press" : "ah_release", sel:1, edge_no:e,
                                 exp_val:prof(e, dir == 0, 4)});
                tick();
                x   = sb_q.pop_front();
                got = obs(x.sel);
                n_cmp++;
                if (got !== x.exp_val) begin
                    n_err++;
                    $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                             x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // STABLE_CYCLES=1: one qualify edge, level follows on edge 4.
    task automatic test_min_stable();
        exp_t       x;
        logic [2:0] got;
        for (int dir = 0; dir < 2; dir++) begin
            button_s1 = (dir != 0);
            for (int e = 1; e <= 6; e++) begin
                sb_q.push_back('{name:(dir == 0) ? "s1_press" : "s1_release", sel:2, edge_no:e,
                                 exp_val:prof(e, dir == 0, 1)});
                tick();
                x   = sb_q.pop_front();
                got = obs(x.sel);
                n_cmp++;
                if (got !== x.exp_val) begin
                    n_err++;
                    $display("FAIL %s edge %0d: got level=%b state=%b, expected level=%b state=%b",
                             x.name, x.edge_no, got[2], got[1:0], x.exp_val[2], x.exp_val[1:0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_release();
        test_bounce();
        test_release_bounce();
        test_reset_mid();
        test_active_high();
        test_min_stable();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_button_debouncer
